delta_controller_output_storer: RTL

Writes back finished output tiles from the PU output buffers to DRAM. It is the write-direction counterpart of the bias loader. When started, it walks all PUs in order and reads each PU's `OUTPUT_CHANNEL` accumulators. Each value is requantised to `BIN_LEN` bits (arithmetic shift, optional ReLU, saturation), packed two per 32-bit word, written to consecutive DRAM words, and the source buffer entry is cleared for the next tile.

---
 rtl/delta_controller_output_storer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/delta_controller_output_storer.sv
// delta_controller_output_storer
// Purpose : drains every PU output buffer to DRAM after a tile finishes. Each
//           accumulator is requantised (arithmetic shift, optional ReLU,
//           saturation), packed two per 32-bit word and written to
//           consecutive DRAM words; the PU buffer is then cleared.
// Latency : 5 cycles per PU with zero-wait DRAM; finished = 5*PU_NUM+1 cycles
//           after the start cycle, plus one cycle per DRAM wait cycle.
// Ports   : clock/reset (sync, active-high); start/out_start_address/
//           shift_amt/relu_en = job request; OB_r_enable/OB_data/OB_clear =
//           output-buffer read and clear; DRAM_Write/Address/WriteData/
//           WriteDone = write request held until accepted; busy/finished =
//           job status.
module delta_controller_output_storer #(
    parameter int PU_NUM         = 4,
    parameter int OUTPUT_CHANNEL = 4,
    parameter int BIN_LEN        = 16,
    parameter int OUT_BIN_LEN    = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] out_start_address,
    input  logic [4:0]  shift_amt,
    input  logic        relu_en,
    output logic [PU_NUM-1:0] OB_r_enable,
    input  logic [PU_NUM-1:0][OUTPUT_CHANNEL-1:0][OUT_BIN_LEN-1:0] OB_data,
    output logic [PU_NUM-1:0] OB_clear,
    output logic        DRAM_Write,
    output logic [31:0] DRAM_Address,
    output logic [31:0] DRAM_WriteData,
    input  logic        DRAM_WriteDone,
    output logic        busy,
    output logic        finished
);

    localparam int WORDS  = OUTPUT_CHANNEL / 2;
    localparam int PU_W   = (PU_NUM > 1) ? $clog2(PU_NUM) : 1;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PACK_W = OUTPUT_CHANNEL * BIN_LEN;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] READ     = 3'd1;
    localparam logic [2:0] CAPTURE  = 3'd2;
    localparam logic [2:0] WRITE_LO = 3'd3;
    localparam logic [2:0] WRITE_HI = 3'd4;
    localparam logic [2:0] NEXT_PU  = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    // Saturation bounds of a BIN_LEN-bit signed value, expressed at
    // accumulator width so the comparison stays in one signed domain.
    localparam logic signed [OUT_BIN_LEN-1:0] SAT_MAX = OUT_BIN_LEN'((64'd1 << (BIN_LEN-1)) - 64'd1);
    localparam logic signed [OUT_BIN_LEN-1:0] SAT_MIN = ~SAT_MAX;

    logic [2:0]        state;
    logic [PU_W-1:0]   pu;
    logic [WORD_W-1:0] word;
    logic [31:0]       addr;
    logic [PACK_W-1:0] pack;
    logic [PACK_W-1:0] qn;
    logic [4:0]        shift_r;
    logic              relu_r;

    function automatic logic [BIN_LEN-1:0] requant(
        input logic signed [OUT_BIN_LEN-1:0] acc,
        input logic [4:0]                    sh,
        input logic                          relu
    );
        logic signed [OUT_BIN_LEN-1:0] s;
        // >>> by >= OUT_BIN_LEN fills with the sign, giving 0 or -1.
        s = acc >>> sh;
        if (relu && s[OUT_BIN_LEN-1]) begin
            s = '0;
        end
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end
        return s[BIN_LEN-1:0];
    endfunction

    // Requantised channels of the PU currently being read; ch0 ends up in
    // the low bits so the first DRAM word is simply the bottom 32 bits.
    always_comb begin
        qn = '0;
        for (int c = 0; c < OUTPUT_CHANNEL; c++) begin
            qn[c*BIN_LEN +: BIN_LEN] = requant(OB_data[pu][c], shift_r, relu_r);
        end
    end

    always_comb begin
        OB_r_enable = '0;
        OB_clear    = '0;
        if (state == READ) begin
            OB_r_enable[pu] = 1'b1;
        end
        if (state == NEXT_PU) begin
            OB_clear[pu] = 1'b1;
        end
    end

    assign DRAM_Write     = (state == WRITE_LO) || (state == WRITE_HI);
    assign DRAM_Address   = addr;
    assign DRAM_WriteData = pack[31:0];
    assign busy           = (state != IDLE);
    assign finished       = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pu      <= '0;
            word    <= '0;
            addr    <= '0;
            pack    <= '0;
            shift_r <= '0;
            relu_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr    <= out_start_address;
                        shift_r <= shift_amt;
                        relu_r  <= relu_en;
                        pu      <= '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    pack  <= qn;
                    word  <= '0;
                    state <= WRITE_LO;
                end
                WRITE_LO: begin
                    if (DRAM_WriteDone) begin
                        addr <= addr + 32'd4;
                        // Shifting the packed channels down presents the next
                        // word in the same cycle the state advances, so the
                        // request can stay high without a gap.
                        pack <= pack >> 32;
                        if (WORDS == 1) begin
                            state <= NEXT_PU;
                        end else begin
                            word  <= WORD_W'(1);
                            state <= WRITE_HI;
                        end
                    end
                end
                WRITE_HI: begin
                    if (DRAM_WriteDone) begin
                        addr <= addr + 32'd4;
                        pack <= pack >> 32;
                        if (word == WORD_W'(WORDS - 1)) begin
                            state <= NEXT_PU;
                        end else begin
                            word <= word + WORD_W'(1);
                        end
                    end
                end
                NEXT_PU: begin
                    if (pu == PU_W'(PU_NUM - 1)) begin
                        state <= DONE;
                    end else begin
                        pu    <= pu + PU_W'(1);
                        state <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
